// File: rtl/mult_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_arbiter_pkg
// Description : Shared types, default sizes and the round-robin pick helper
//               for the shared shift-add multiplier arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_arbiter_pkg;

    localparam int c_W_DEFAULT     = 4;
    localparam int c_N_REQ_DEFAULT = 4;
    localparam int c_MAX_REQ       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // First requester with valid set, searching last+1, last+2, ... with
    // wrap-around over n requesters. Returns last when nothing is valid.
    function automatic logic [2:0] rr_pick(input logic [c_MAX_REQ-1:0] valid,
                                           input int n,
                                           input int last);
        logic [2:0] w_pick;
        logic [2:0] w_idx;
        w_pick = 3'(last);
        // Scan from farthest to nearest so the nearest valid entry wins.
        for (int k = n; k >= 1; k--) begin
            w_idx = 3'((last + k) % n);
            if (valid[w_idx]) begin
                w_pick = w_idx;
            end
        end
        return w_pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_arbiter_shift_add_core.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_core
// Description : W-iteration shift-add multiplier. Latches operands on start,
//               performs one partial-product step per clock and flags the
//               final step combinationally together with its result.
//               MULT_ARBITER_SIGNED_EN selects a two's-complement multiply.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_core
    import mult_arbiter_pkg::*;
#(
    parameter int W = c_W_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] p
);

    localparam int c_CNT_W = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [2*W-1:0]     r_acc;
    logic [c_CNT_W-1:0] r_count;
    logic               r_run;

    logic [2*W-1:0]     w_ext;
    logic [2*W-1:0]     w_shift;
    logic [2*W-1:0]     w_next;
    logic               w_last;

`ifdef MULT_ARBITER_SIGNED_EN
    assign w_ext = {{W{r_a[W-1]}}, r_a};
`else
    assign w_ext = {{W{1'b0}}, r_a};
`endif

    assign w_shift = w_ext << r_count;
    assign w_last  = (r_count == c_CNT_W'(W - 1));

    // Accumulator value after the current iteration's partial product.
    always_comb begin
        w_next = r_acc;
        if (r_b[r_count]) begin
`ifdef MULT_ARBITER_SIGNED_EN
            // The multiplier's sign bit carries negative weight.
            if (w_last) begin
                w_next = r_acc - w_shift;
            end else begin
                w_next = r_acc + w_shift;
            end
`else
            w_next = r_acc + w_shift;
`endif
        end
    end

    assign done = r_run && w_last;
    assign p    = w_next;

    // Operand latch and iteration sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_count <= '0;
            r_run   <= 1'b0;
        end else if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_count <= '0;
            r_run   <= 1'b1;
        end else if (r_run) begin
            r_acc   <= w_next;
            r_count <= r_count + c_CNT_W'(1);
            if (w_last) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_arbiter
// Description : Round-robin arbiter and sequencer sharing one shift-add
//               multiplier between N_REQ requesters, with valid/ready
//               request and response channels.
//               Optional build macro: MULT_ARBITER_SIGNED_EN (signed multiply).
// Revision    : 1.0 - initial release
// ============================================================================
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int N_REQ = c_N_REQ_DEFAULT,
    parameter int W     = c_W_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*W-1:0]            req_a,
    input  logic [N_REQ*W-1:0]            req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [2*W-1:0]                rsp_p,
    output logic [$clog2(N_REQ)-1:0]      rsp_id,
    output logic                          busy
);

    localparam int ID_W = $clog2(N_REQ);

    state_t          r_state;
    logic [ID_W-1:0] r_last;
    logic [ID_W-1:0] r_id;

    logic [2:0]      w_pick;
    logic [ID_W-1:0] w_grant;
    logic            w_any;
    logic            w_accept;
    logic [W-1:0]    w_a [N_REQ];
    logic [W-1:0]    w_b [N_REQ];
    logic            w_done;
    logic [2*W-1:0]  w_p;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign w_a[i] = req_a[i*W +: W];
        assign w_b[i] = req_b[i*W +: W];
    end

    assign w_pick   = rr_pick(c_MAX_REQ'(req_valid), N_REQ, int'(r_last));
    assign w_grant  = ID_W'(w_pick);
    assign w_any    = |req_valid;
    assign w_accept = (r_state == IDLE) && w_any;

    // Grant is offered only while idle, and only to the round-robin winner.
    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    shift_add_core #(
        .W (W)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .start (w_accept),
        .a     (w_a[w_grant]),
        .b     (w_b[w_grant]),
        .done  (w_done),
        .p     (w_p)
    );

    // Job sequencing, round-robin pointer and response channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_last    <= ID_W'(N_REQ - 1);
            r_id      <= '0;
            rsp_valid <= 1'b0;
            rsp_p     <= '0;
            rsp_id    <= '0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_id    <= w_grant;
                        r_last  <= w_grant;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_done) begin
                        rsp_p     <= w_p;
                        rsp_id    <= r_id;
                        rsp_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_arbiter
// Description : Self-checking bench for mult_arbiter: directed scenarios plus
//               randomized jobs against a round-robin / arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int AW = N * W;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [AW-1:0]   req_a;
    logic [AW-1:0]   req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [2*W-1:0]  rsp_p;
    logic [1:0]      rsp_id;
    logic            busy;

    int tests   = 0;
    int fails   = 0;
    int tb_last = N - 1;

    mult_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        int ia;
        int ib;
`ifdef MULT_ARBITER_SIGNED_EN
        ia = int'($signed(a));
        ib = int'($signed(b));
`else
        ia = int'(a);
        ib = int'(b);
`endif
        return (2*W)'(ia * ib);
    endfunction

    function automatic int ref_winner(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // One full job: offer, accept, W iterations, optional stall, handshake.
    task automatic do_job(input logic [N-1:0] valid, input logic [AW-1:0] a,
                          input logic [AW-1:0] b, input int stall, input bit hold,
                          input bit use_exp, input logic [2*W-1:0] exp_const);
        int w;
        logic [N-1:0] exp_rdy;
        logic [2*W-1:0] exp_p;
        req_valid = valid;
        req_a = a;
        req_b = b;
        #1;
        w = ref_winner(valid, tb_last);
        exp_rdy = '0;
        exp_rdy[w] = 1'b1;
        exp_p = use_exp ? exp_const : ref_mul(a[w*W +: W], b[w*W +: W]);
        check("grant_ready", 32'(req_ready), 32'(exp_rdy));
        check("idle_busy", 32'(busy), 0);
        @(posedge clk); #1;
        tb_last = w;
        if (!hold) req_valid = '0;
        req_a = AW'($urandom);
        req_b = AW'($urandom);
        #1;
        check("run_busy", 32'(busy), 1);
        check("run_no_ready", 32'(req_ready), 0);
        for (int i = 1; i < W; i++) begin
            @(posedge clk); #1;
            check("early_valid", 32'(rsp_valid), 0);
        end
        @(posedge clk); #1;
        check("rsp_valid", 32'(rsp_valid), 1);
        check("rsp_p", 32'(rsp_p), 32'(exp_p));
        check("rsp_id", 32'(rsp_id), 32'(w));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(rsp_valid), 1);
            check("stall_p", 32'(rsp_p), 32'(exp_p));
            check("stall_id", 32'(rsp_id), 32'(w));
            check("stall_no_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("post_valid", 32'(rsp_valid), 0);
        check("post_busy", 32'(busy), 0);
        if (hold) begin
            exp_rdy = '0;
            exp_rdy[ref_winner(req_valid, tb_last)] = 1'b1;
            check("post_idle_ready", 32'(req_ready), 32'(exp_rdy));
        end
    endtask

`ifdef MULT_ARBITER_SIGNED_EN
    localparam logic [7:0] c_P_B_D = 8'd15;
    localparam logic [7:0] c_P_FF  = 8'd1;
    localparam logic [7:0] c_P_78  = 8'hC8;
`else
    localparam logic [7:0] c_P_B_D = 8'd143;
    localparam logic [7:0] c_P_FF  = 8'd225;
    localparam logic [7:0] c_P_78  = 8'd56;
`endif

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_p", 32'(rsp_p), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        reset = 1'b0;
        tb_last = N - 1;

        // All requesters valid: grants rotate 0,1,2,3,0.
        for (int j = 0; j < 5; j++) begin
            do_job(4'hF, 16'h9D73, 16'h2B5E, 0, 1'b1, 1'b0, '0);
        end
        req_valid = '0;

        // Req0 only, 4'b1011 x 4'b1101.
        do_job(4'b0001, 16'h000B, 16'h000D, 0, 1'b0, 1'b1, c_P_B_D);

        // Req2 15 x 15 with ten cycles of backpressure.
        do_job(4'b0100, 16'h0F00, 16'h0F00, 10, 1'b1, 1'b1, c_P_FF);
        req_valid = '0;

        // Zero operands keep the fixed latency.
        do_job(4'b0010, 16'h0000, 16'h0090, 0, 1'b0, 1'b1, 8'd0);
        do_job(4'b1000, 16'h7000, 16'h0000, 0, 1'b0, 1'b1, 8'd0);

        // 4'b0111 x 4'b1000.
        do_job(4'b0001, 16'h0007, 16'h0008, 0, 1'b0, 1'b1, c_P_78);

        // Reset two cycles into RUN discards the job and the pointer.
        req_valid = 4'b0010;
        req_a = 16'h00F0;
        req_b = 16'h00F0;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_valid", 32'(rsp_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_p", 32'(rsp_p), 0);
        reset = 1'b0;
        tb_last = N - 1;
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk); #1;
            check("midrst_no_rsp", 32'(rsp_valid), 0);
        end
        do_job(4'b1001, 16'h5003, 16'h6002, 0, 1'b0, 1'b0, '0);

        // Randomized jobs against the model.
        for (int j = 0; j < 20; j++) begin
            do_job(4'($urandom_range(1, 15)), AW'($urandom), AW'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom), 1'b0, '0);
        end
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
